// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder over a word-organised RAM.
// Fixed LATENCY cycles in ACCESS, then a one-cycle RESP with ready (and err for illegal requests).
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_cnt;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [2:0]       r_funct3;
    logic             r_rd;
    logic             r_wr;
    logic [31:0]      r_rdata;
    logic             r_ready;
    logic             r_err;
    logic             r_busy;
    logic [31:0]      r_mem [DEPTH];

    logic             w_start;
    logic             w_cnt_done;
    logic             w_commit;
    logic             w_is_load;
    logic             w_is_store;
    logic             w_f3_ok;
    logic             w_align_ok;
    logic             w_range_ok;
    logic             w_legal;
    logic [IDXW-1:0]  w_idx;
    logic [31:0]      w_word;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic [3:0]       w_be;
    logic [31:0]      w_lane;
    logic [31:0]      w_mask;
    logic [31:0]      w_merged;

    assign w_start    = rd_en | wr_en;
    assign w_cnt_done = (r_cnt == 4'(LATENCY - 1));
    assign w_commit   = (r_state == ST_ACCESS) && w_cnt_done;
    assign w_is_load  = r_rd & ~r_wr;
    assign w_is_store = r_wr & ~r_rd;
    assign w_range_ok = (r_addr[31:2] < 30'(DEPTH));
    assign w_legal    = (w_is_load | w_is_store) & w_f3_ok & w_align_ok & w_range_ok;
    assign w_idx      = r_addr[IDXW+1:2];
    assign w_word     = r_mem[w_idx];
    assign w_byte     = w_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half     = r_addr[1] ? w_word[31:16] : w_word[15:0];
    assign w_merged   = (w_word & ~w_mask) | (w_lane & w_mask);

    // Next-state logic for the IDLE/ACCESS/RESP sequence
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_next = ST_ACCESS; else w_next = ST_IDLE;
            ST_ACCESS: if (w_cnt_done) w_next = ST_RESP; else w_next = ST_ACCESS;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Legality of the latched request: encoding and natural alignment by access size
    always_comb begin
        w_f3_ok    = 1'b0;
        w_align_ok = 1'b0;
        case (r_funct3)
            3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
            3'b100, 3'b101:         w_f3_ok = w_is_load;
            default:                w_f3_ok = 1'b0;
        endcase
        case (r_funct3[1:0])
            2'b00:   w_align_ok = 1'b1;
            2'b01:   w_align_ok = ~r_addr[0];
            2'b10:   w_align_ok = (r_addr[1:0] == 2'b00);
            default: w_align_ok = 1'b0;
        endcase
    end

    // Load formatting and store byte-lane merge
    always_comb begin
        w_load = 32'd0;
        w_be   = 4'd0;
        w_lane = r_wdata;
        w_mask = 32'd0;
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
        case (r_funct3[1:0])
            2'b00: begin
                w_be   = 4'b0001 << r_addr[1:0];
                w_lane = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = r_addr[1] ? 4'b1100 : 4'b0011;
                w_lane = {2{r_wdata[15:0]}};
            end
            2'b10: begin
                w_be   = 4'b1111;
                w_lane = r_wdata;
            end
            default: begin
                w_be   = 4'b0000;
                w_lane = r_wdata;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            w_mask[8*i +: 8] = {8{w_be[i]}};
        end
    end

    // State, latency counter and request capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_funct3 <= 3'd0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && w_start) begin
                r_addr   <= addr;
                r_wdata  <= wdata;
                r_funct3 <= funct3;
                r_rd     <= rd_en;
                r_wr     <= wr_en;
            end
            if ((r_state == ST_ACCESS) && !w_cnt_done) begin
                r_cnt <= r_cnt + 4'd1;
            end else begin
                r_cnt <= 4'd0;
            end
        end
    end

    // Registered response outputs; only the ACCESS->RESP edge can raise them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'd0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= w_commit;
            r_err   <= w_commit & ~w_legal;
            r_rdata <= (w_commit && w_legal && w_is_load) ? w_load : 32'd0;
            r_busy  <= (w_next != ST_IDLE);
        end
    end

    // RAM contents survive reset; an aborted transaction never reaches the commit edge
    always_ff @(posedge clk) begin
        if (w_commit && w_legal && w_is_store) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign rdata = r_rdata;
    assign ready = r_ready;
    assign err   = r_err;
    assign busy  = r_busy;
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized
// traffic against a byte-addressed little-endian memory model.
module tb_data_mem_responder;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;
    localparam int WIN     = 256;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    int          n_checks;
    int          n_fails;
    logic [7:0]  mb [WIN];

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .wdata(wdata), .funct3(funct3), .rdata(rdata), .ready(ready),
        .err(err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference: byte memory, legality from size/alignment/range rules.
    task automatic model_access(input bit rd, input bit wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [2:0] f3,
                                output bit e, output logic [31:0] rv);
        int  sz;
        bit  legal;
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
        legal = (rd != wr);
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) legal = 0;
        if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) legal = 0;
        if (sz == 0) legal = 0;
        else if ((a % sz) != 0) legal = 0;
        if ((a / 4) >= DEPTH) legal = 0;
        e  = !legal;
        rv = 32'd0;
        if (legal && wr) begin
            for (int i = 0; i < sz; i++) mb[int'(a) + i] = wd[8*i +: 8];
        end
        if (legal && rd) begin
            for (int i = 0; i < sz; i++) rv = rv | (32'(mb[int'(a) + i]) << (8 * i));
            if (!f3[2] && sz < 4 && rv[8*sz-1]) rv = rv | (32'hFFFF_FFFF << (8 * sz));
        end
    endtask

    task automatic transact(input string tag, input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [2:0] f3, output logic [31:0] got);
        bit          e_exp;
        logic [31:0] r_exp;
        int          n;
        bit          busy_ok;
        @(negedge clk);
        rd_en = rd; wr_en = wr; addr = a; wdata = wd; funct3 = f3;
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        addr = $urandom; wdata = $urandom; funct3 = 3'($urandom_range(0, 7));
        n = 1;
        busy_ok = (busy === 1'b1);
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            busy_ok = busy_ok && (busy === 1'b1);
        end
        model_access(rd, wr, a, wd, f3, e_exp, r_exp);
        check_eq({tag, "_lat"}, 32'(n), 32'(LATENCY + 1));
        check_eq({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        check_eq({tag, "_err"}, {31'd0, err}, {31'd0, e_exp});
        check_eq({tag, "_rdata"}, rdata, r_exp);
        got = rdata;
        @(negedge clk);
        check_eq({tag, "_done"}, {30'd0, ready, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [31:0] exp10;
        bit          e_dummy;
        bit          rd;
        bit          wr;
        int          n_rdy;
        int          bad_phase;
        n_checks = 0;
        n_fails  = 0;
        for (int i = 0; i < WIN; i++) mb[i] = 8'd0;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        addr = 32'd0; wdata = 32'd0; funct3 = 3'd0;
        #1;
        check_eq("reset_out", {rdata[31:0] | {29'd0, ready, err, busy}}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("reset_idle", {29'd0, ready, err, busy}, 32'd0);

        for (int w = 0; w < WIN / 4; w++) transact("init", 1'b0, 1'b1, 32'(4 * w), 32'd0, 3'b010, got);

        transact("sw10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, got);
        transact("lw10", 1'b1, 1'b0, 32'h10, 32'd0, 3'b010, got);
        check_eq("lw10_const", got, 32'hDEADBEEF);

        transact("sw10b", 1'b0, 1'b1, 32'h10, 32'h11223344, 3'b010, got);
        transact("sb11", 1'b0, 1'b1, 32'h11, 32'h000000AA, 3'b000, got);
        transact("lw10m", 1'b1, 1'b0, 32'h10, 32'd0, 3'b010, got);
        check_eq("sb_merge", got, 32'h1122AA44);
        transact("lb11", 1'b1, 1'b0, 32'h11, 32'd0, 3'b000, got);
        check_eq("lb_sext", got, 32'hFFFFFFAA);
        transact("lbu11", 1'b1, 1'b0, 32'h11, 32'd0, 3'b100, got);
        check_eq("lbu_zext", got, 32'h000000AA);

        transact("sh22", 1'b0, 1'b1, 32'h22, 32'h00008001, 3'b001, got);
        transact("lh22", 1'b1, 1'b0, 32'h22, 32'd0, 3'b001, got);
        check_eq("lh_sext", got, 32'hFFFF8001);
        transact("lhu22", 1'b1, 1'b0, 32'h22, 32'd0, 3'b101, got);
        check_eq("lhu_zext", got, 32'h00008001);
        transact("lw20", 1'b1, 1'b0, 32'h20, 32'd0, 3'b010, got);
        check_eq("sh_lane", got, 32'h80010000);

        transact("lw13", 1'b1, 1'b0, 32'h13, 32'd0, 3'b010, got);
        transact("sh21", 1'b0, 1'b1, 32'h21, 32'h0000FFFF, 3'b001, got);
        transact("lw20b", 1'b1, 1'b0, 32'h20, 32'd0, 3'b010, got);
        check_eq("sh21_nowrite", got, 32'h80010000);
        transact("lw_oor", 1'b1, 1'b0, 32'(4 * DEPTH), 32'd0, 3'b010, got);
        transact("ld011", 1'b1, 1'b0, 32'h10, 32'd0, 3'b011, got);
        transact("rdwr", 1'b1, 1'b1, 32'h24, 32'hCAFEF00D, 3'b010, got);
        transact("lw24", 1'b1, 1'b0, 32'h24, 32'd0, 3'b010, got);
        check_eq("rdwr_nowrite", got, 32'h00000000);

        // Held read enable: a response every LATENCY+2 cycles, phase-locked to the start.
        model_access(1'b1, 1'b0, 32'h10, 32'd0, 3'b010, e_dummy, exp10);
        @(negedge clk);
        rd_en = 1'b1; addr = 32'h10; funct3 = 3'b010;
        n_rdy = 0;
        bad_phase = 0;
        for (int i = 1; i <= 10 * (LATENCY + 2); i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                n_rdy++;
                if ((i % (LATENCY + 2)) != LATENCY + 1) bad_phase++;
                check_eq("b2b_rdata", rdata, exp10);
            end
        end
        rd_en = 1'b0;
        check_eq("b2b_count", 32'(n_rdy), 32'd10);
        check_eq("b2b_phase", 32'(bad_phase), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check_eq("b2b_idle", {31'd0, busy}, 32'd0);

        // Reset during ACCESS of a store: aborted, no pulse, no commit.
        @(negedge clk);
        wr_en = 1'b1; addr = 32'h30; wdata = 32'h12345678; funct3 = 3'b010;
        @(negedge clk);
        wr_en = 1'b0;
        check_eq("abort_busy_pre", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_out", rdata | {29'd0, ready, err, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_rdy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready === 1'b1) n_rdy++;
        end
        check_eq("abort_noready", 32'(n_rdy), 32'd0);
        transact("lw30", 1'b1, 1'b0, 32'h30, 32'd0, 3'b010, got);
        check_eq("abort_nocommit", got, 32'h00000000);

        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 9))
                0:       begin rd = 1'b1; wr = 1'b1; end
                1, 2, 3, 4: begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b0; end
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
            else a = 32'($urandom_range(0, WIN - 1));
            transact("rand", rd, wr, a, $urandom, 3'($urandom_range(0, 7)), got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
